// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time,
// hands it to decode and waits for the next PC from write-back.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_err,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic             out_fault,
  input  logic             out_ready,
  input  logic             wb_valid,
  input  logic [31:0]      wb_dnpc,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,
    S_RESP,
    S_HOLD,
    S_WAIT_WB
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               vld_q, vld_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        opc_q, opc_d;
  logic               flt_q, flt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and registered-output decode for the fetch sequence.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    flt_d   = flt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (imem_resp_valid) begin
          state_d = S_HOLD;
          vld_d   = 1'b1;
          inst_d  = imem_resp_err ? 32'h0 : imem_resp_data;
          flt_d   = imem_resp_err;
          opc_d   = pc_q;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_WAIT_WB;
          vld_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_WB: begin
        if (wb_valid) begin
          pc_d = {wb_dnpc[31:2], 2'b00};
          if (wb_dnpc[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            // misaligned target: fault straight to decode, skip memory
            state_d = S_HOLD;
            vld_d   = 1'b1;
            inst_d  = 32'h0;
            flt_d   = 1'b1;
            opc_d   = wb_dnpc;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      inst_q  <= 32'h0;
      opc_q   <= RESET_PC;
      flt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      flt_q   <= flt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = vld_q;
  assign out_inst       = inst_q;
  assign out_pc         = opc_q;
  assign out_fault      = flt_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected fetches queued at request
// acceptance (or misaligned redirect) and popped at decode handshake.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        out_ready;
  logic        wb_valid;
  logic [31:0] wb_dnpc;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] acc_addr;
  logic        pend_err;

  ifu_fetch #(
    .RESET_PC (32'h8000_0000),
    .CNT_W    (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_fault       (out_fault),
    .out_ready       (out_ready),
    .wb_valid        (wb_valid),
    .wb_dnpc         (wb_dnpc),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h0010_0093 ^ (a << 8);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // present a request, stall it, then accept it; queue the expectation
  task automatic do_req(input int stall,
                        input logic [31:0] exp_addr,
                        input logic err);
    exp_t e;
    imem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("req_v_stall", 64'(imem_req_valid), 64'd1);
      chk("req_addr_stall", 64'(imem_req_addr), 64'(exp_addr));
      @(negedge clk);
    end
    chk("req_v", 64'(imem_req_valid), 64'd1);
    chk("req_addr", 64'(imem_req_addr), 64'(exp_addr));
    imem_req_ready = 1'b1;
    acc_addr = imem_req_addr;
    pend_err = err;
    e.inst  = err ? 32'h0 : inst_of(imem_req_addr);
    e.pc    = imem_req_addr;
    e.fault = err;
    sb_q.push_back(e);
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("req_v_drop", 64'(imem_req_valid), 64'd0);
  endtask

  // return the response 'delay' cycles after acceptance
  task automatic do_resp(input int delay, input logic glitch);
    for (int i = 1; i < delay; i++) begin
      wb_valid = glitch;
      wb_dnpc  = 32'h9000_0000;
      chk("out_v_wait", 64'(out_valid), 64'd0);
      chk("req_v_resp", 64'(imem_req_valid), 64'd0);
      @(negedge clk);
    end
    wb_valid        = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = inst_of(acc_addr);
    imem_resp_err   = pend_err;
    chk("out_v_pre", 64'(out_valid), 64'd0);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = 32'hdead_beef;
    chk("out_v", 64'(out_valid), 64'd1);
  endtask

  // hold back-pressure, then consume and compare against the scoreboard
  task automatic consume(input int hold);
    logic [31:0] c0, i0, p0;
    exp_t e;
    c0 = fetch_cnt;
    i0 = out_inst;
    p0 = out_pc;
    for (int i = 0; i < hold; i++) begin
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_inst", 64'(out_inst), 64'(i0));
      chk("hold_pc", 64'(out_pc), 64'(p0));
      chk("hold_noreq", 64'(imem_req_valid), 64'd0);
      chk("hold_cnt", 64'(fetch_cnt), 64'(c0));
      @(negedge clk);
    end
    chk("out_v_hs", 64'(out_valid), 64'd1);
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("out_inst", 64'(out_inst), 64'(e.inst));
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("out_fault", 64'(out_fault), 64'(e.fault));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_v_drop", 64'(out_valid), 64'd0);
    chk("cnt_inc", 64'(fetch_cnt), 64'(c0 + 32'd1));
    chk("wait_noreq", 64'(imem_req_valid), 64'd0);
  endtask

  // next PC from write-back
  task automatic wb(input logic [31:0] dnpc);
    exp_t e;
    wb_valid = 1'b1;
    wb_dnpc  = dnpc;
    if (dnpc[1:0] != 2'b00) begin
      e.inst  = 32'h0;
      e.pc    = dnpc;
      e.fault = 1'b1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    if (dnpc[1:0] != 2'b00) begin
      chk("mis_noreq", 64'(imem_req_valid), 64'd0);
      chk("mis_out_v", 64'(out_valid), 64'd1);
    end else begin
      chk("redir_v", 64'(imem_req_valid), 64'd1);
      chk("redir_addr", 64'(imem_req_addr), 64'({dnpc[31:2], 2'b00}));
    end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    out_ready       = 1'b0;
    wb_valid        = 1'b0;
    wb_dnpc         = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_out_v", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_fault", 64'(out_fault), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);
    rst = 1'b1;

    do_req(0, 32'h8000_0000, 1'b0);
    do_resp(1, 1'b0);
    consume(5);
    chk("cnt_first", 64'(fetch_cnt), 64'd1);

    wb(32'h8000_0004);
    do_req(3, 32'h8000_0004, 1'b0);
    do_resp(4, 1'b0);
    consume(0);

    wb(32'h8000_0010);
    do_req(0, 32'h8000_0010, 1'b0);
    do_resp(2, 1'b1);
    consume(1);

    wb(32'h8000_0006);
    consume(0);

    wb(32'h8000_0008);
    do_req(0, 32'h8000_0008, 1'b1);
    do_resp(1, 1'b0);
    consume(0);
    chk("cnt_five", 64'(fetch_cnt), 64'd5);

    wb(32'h8000_000c);
    do_req(0, 32'h8000_000c, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_v", 64'(out_valid), 64'd0);
    chk("arst_inst", 64'(out_inst), 64'd0);
    chk("arst_fault", 64'(out_fault), 64'd0);
    chk("arst_cnt", 64'(fetch_cnt), 64'd0);
    chk("arst_req_v", 64'(imem_req_valid), 64'd1);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    do_req(0, 32'h8000_0000, 1'b0);
    do_resp(1, 1'b0);
    consume(0);
    chk("cnt_after_rst", 64'(fetch_cnt), 64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
